// File: rtl/pkt_shifter.sv
// pkt_shifter: serial packet shifter for the radio link.
// RX mode accumulates PACKET_SIZE strobed bits into rx_data; TX mode shifts
// a preamble followed by the payload out on dout, one bit per strobe.
module pkt_shifter #(
  parameter int unsigned PACKET_SIZE   = 64,
  parameter int unsigned PREAMBLE_SIZE = 8,
  parameter logic [PREAMBLE_SIZE-1:0] PREAMBLE_PATTERN = PREAMBLE_SIZE'(8'b10101010)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX,
  input  logic                   sh_en,
  input  logic                   fsm_rst,
  input  logic                   din,
  input  logic                   tx_load,
  input  logic [PACKET_SIZE-1:0] tx_data,
  output logic [PACKET_SIZE-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   tx_rdy,
  output logic                   dout,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam int unsigned FRAME_SIZE = PREAMBLE_SIZE + PACKET_SIZE;
  localparam int unsigned BCW        = $clog2(PACKET_SIZE + 1);
  localparam int unsigned TCW        = $clog2(FRAME_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RX_SHIFT = 2'd1,
    S_TX_WAIT  = 2'd2,
    S_TX_SHIFT = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_din_m;
  logic                   r_din_s;
  logic [PACKET_SIZE-1:0] r_shreg;
  logic [BCW-1:0]         r_bit_cnt;
  logic [FRAME_SIZE-1:0]  r_frame;
  logic [TCW-1:0]         r_tx_cnt;
  logic [PACKET_SIZE-1:0] r_rx_data;
  logic                   r_rx_valid;
  logic                   r_tx_rdy;
  logic                   r_dout;
  logic                   r_tx_busy;
  logic                   r_tx_done;

  logic                   w_rx_full;
  logic                   w_tx_last;
  logic [PACKET_SIZE-1:0] w_sh_base;
  logic [BCW-1:0]         w_cnt_base;

  // A completed packet is handed off this cycle, so a coincident strobe starts a fresh one
  assign w_rx_full  = (r_bit_cnt == BCW'(PACKET_SIZE));
  assign w_tx_last  = (r_tx_cnt == TCW'(FRAME_SIZE));
  assign w_sh_base  = w_rx_full ? '0 : r_shreg;
  assign w_cnt_base = w_rx_full ? '0 : r_bit_cnt;

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_rdy   = r_tx_rdy;
  assign dout     = r_dout;
  assign tx_busy  = r_tx_busy;
  assign tx_done  = r_tx_done;

  // Two-flop synchroniser for the asynchronous demodulated bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_din_m <= 1'b0;
      r_din_s <= 1'b0;
    end else begin
      r_din_m <= din;
      r_din_s <= r_din_m;
    end
  end

  // Mode FSM with shift datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_frame    <= '0;
      r_tx_cnt   <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_rdy   <= 1'b0;
      r_dout     <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dout    <= 1'b0;
          r_tx_rdy  <= 1'b0;
          r_tx_busy <= 1'b0;
          if (RX) begin
            r_state   <= S_RX_SHIFT;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
          end else if (tx_load) begin
            r_state   <= S_TX_WAIT;
            r_frame   <= {PREAMBLE_PATTERN, tx_data};
            r_tx_cnt  <= '0;
            r_tx_rdy  <= 1'b1;
            r_tx_busy <= 1'b1;
          end
        end

        S_RX_SHIFT: begin
          if (!RX) begin
            // Leaving receive mode drops any partial packet
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
          end else begin
            if (w_rx_full) begin
              r_rx_data  <= r_shreg;
              r_rx_valid <= 1'b1;
            end
            if (fsm_rst) begin
              r_shreg   <= '0;
              r_bit_cnt <= '0;
            end else if (sh_en) begin
              r_shreg   <= {w_sh_base[PACKET_SIZE-2:0], r_din_s};
              r_bit_cnt <= BCW'(w_cnt_base + BCW'(1));
            end else if (w_rx_full) begin
              r_shreg   <= '0;
              r_bit_cnt <= '0;
            end
          end
        end

        S_TX_WAIT: begin
          r_dout <= 1'b0;
          if (RX) begin
            r_state   <= S_IDLE;
            r_tx_rdy  <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
          end else if (sh_en) begin
            r_dout   <= r_frame[FRAME_SIZE-1];
            r_frame  <= {r_frame[FRAME_SIZE-2:0], 1'b0};
            r_tx_cnt <= TCW'(1);
            r_tx_rdy <= 1'b0;
            r_state  <= S_TX_SHIFT;
          end
        end

        S_TX_SHIFT: begin
          if (RX) begin
            r_state   <= S_IDLE;
            r_dout    <= 1'b0;
            r_tx_rdy  <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
          end else if (w_tx_last) begin
            // Last bit has been on dout for a cycle; close the frame
            r_state   <= S_IDLE;
            r_dout    <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b1;
            r_tx_cnt  <= '0;
          end else if (sh_en) begin
            r_dout   <= r_frame[FRAME_SIZE-1];
            r_frame  <= {r_frame[FRAME_SIZE-2:0], 1'b0};
            r_tx_cnt <= TCW'(r_tx_cnt + TCW'(1));
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_shifter.sv
// tb_pkt_shifter: directed self-checking bench for pkt_shifter.
module tb_pkt_shifter;

  localparam logic [63:0] P_RX1   = 64'hDEADBEEF_01234567;
  localparam logic [63:0] P_A5    = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] P_SIM   = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] P_RST   = 64'h3C3C_F00F_1234_8001;
  localparam logic [63:0] P_TX    = 64'h0123456789ABCDEF;
  localparam logic [71:0] TX_FRAME = {8'hAA, 64'h0123456789ABCDEF};

  logic        clk;
  logic        rst;
  logic        RX;
  logic        sh_en;
  logic        fsm_rst;
  logic        din;
  logic        tx_load;
  logic [63:0] tx_data;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        tx_rdy;
  logic        dout;
  logic        tx_busy;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rx_valid = 0;
  int n_tx_done  = 0;
  int v0;
  int d0;

  pkt_shifter dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .sh_en    (sh_en),
    .fsm_rst  (fsm_rst),
    .din      (din),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_rdy   (tx_rdy),
    .dout     (dout),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // 10 MHz clock
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Pulse counters sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (rx_valid) n_rx_valid++;
    if (tx_done)  n_tx_done++;
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe after gap idle cycles; entered and left at a negedge
  task automatic pulse_sh(input int gap);
    repeat (gap) @(negedge clk);
    sh_en = 1'b1;
    @(negedge clk);
    sh_en = 1'b0;
  endtask

  task automatic strobe(input logic b, input int gap);
    din = b;
    pulse_sh(gap);
  endtask

  task automatic send_word(input logic [63:0] w, input int gap);
    for (int i = 63; i >= 0; i--) strobe(w[i], gap);
  endtask

  initial begin
    rst = 1'b0; RX = 1'b0; sh_en = 1'b0; fsm_rst = 1'b0;
    din = 1'b0; tx_load = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rx_data",  rx_data,  72'h0);
    chk("rst_rx_valid", rx_valid, 72'h0);
    chk("rst_tx_rdy",   tx_rdy,   72'h0);
    chk("rst_dout",     dout,     72'h0);
    chk("rst_tx_busy",  tx_busy,  72'h0);
    chk("rst_tx_done",  tx_done,  72'h0);
    rst = 1'b1;
    @(negedge clk);

    // Receive one packet with widely spaced strobes
    RX = 1'b1;
    v0 = n_rx_valid;
    for (int i = 63; i >= 1; i--) strobe(P_RX1[i], 998);
    chk("rx_no_early", 72'(n_rx_valid - v0), 72'h0);
    strobe(P_RX1[0], 998);
    chk("rx_valid_lat0", rx_valid, 72'h0);
    @(negedge clk);
    chk("rx_valid_lat1", rx_valid, 72'h1);
    chk("rx_data_1", rx_data, 72'(P_RX1));
    @(negedge clk);
    chk("rx_valid_pulse", rx_valid, 72'h0);

    // 65th strobe starts a new packet without touching rx_data
    strobe(1'b1, 3);
    repeat (2) @(negedge clk);
    chk("rx_65_hold", rx_data, 72'(P_RX1));
    chk("rx_65_count", 72'(n_rx_valid - v0), 72'h1);

    // fsm_rst after 20 strobes restarts accumulation
    for (int i = 0; i < 20; i++) strobe(1'b1, 3);
    fsm_rst = 1'b1;
    @(negedge clk);
    fsm_rst = 1'b0;
    v0 = n_rx_valid;
    send_word(P_A5, 3);
    repeat (2) @(negedge clk);
    chk("fsmrst_count", 72'(n_rx_valid - v0), 72'h1);
    chk("fsmrst_data", rx_data, 72'(P_A5));

    // sh_en and fsm_rst together: reset wins and the bit is dropped
    for (int i = 0; i < 10; i++) strobe(1'b1, 3);
    din = 1'b1;
    repeat (3) @(negedge clk);
    sh_en = 1'b1; fsm_rst = 1'b1;
    @(negedge clk);
    sh_en = 1'b0; fsm_rst = 1'b0;
    v0 = n_rx_valid;
    for (int i = 63; i >= 1; i--) strobe(P_SIM[i], 3);
    repeat (2) @(negedge clk);
    chk("sim_no_early", 72'(n_rx_valid - v0), 72'h0);
    strobe(P_SIM[0], 3);
    repeat (2) @(negedge clk);
    chk("sim_count", 72'(n_rx_valid - v0), 72'h1);
    chk("sim_data", rx_data, 72'(P_SIM));

    // Dropping RX mid-packet discards it
    for (int i = 0; i < 10; i++) strobe(1'b0, 3);
    v0 = n_rx_valid;
    RX = 1'b0;
    repeat (4) @(negedge clk);
    chk("rxdrop_count", 72'(n_rx_valid - v0), 72'h0);
    chk("rxdrop_data", rx_data, 72'(P_SIM));

    // Reset after 40 strobes, then a fresh packet
    RX = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) strobe(1'b1, 3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rstmid_data", rx_data, 72'h0);
    chk("rstmid_valid", rx_valid, 72'h0);
    v0 = n_rx_valid;
    send_word(P_RST, 3);
    repeat (2) @(negedge clk);
    chk("rstmid_count", 72'(n_rx_valid - v0), 72'h1);
    chk("rstmid_new", rx_data, 72'(P_RST));

    // Transmit preamble plus payload
    RX = 1'b0;
    repeat (2) @(negedge clk);
    tx_data = P_TX; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0; tx_data = '0;
    chk("tx_rdy_wait", tx_rdy, 72'h1);
    chk("tx_busy_wait", tx_busy, 72'h1);
    chk("tx_dout_wait", dout, 72'h0);
    repeat (5) @(negedge clk);
    chk("tx_rdy_hold", tx_rdy, 72'h1);
    d0 = n_tx_done;
    for (int i = 0; i < 72; i++) begin
      if (i == 10) begin
        tx_load = 1'b1; tx_data = '1;
        @(negedge clk);
        tx_load = 1'b0; tx_data = '0;
      end
      pulse_sh(2);
      chk($sformatf("tx_bit%0d", i), dout, 72'(TX_FRAME[71-i]));
      if (i == 0) chk("tx_rdy_clear", tx_rdy, 72'h0);
      if (i < 71) begin
        @(negedge clk);
        chk($sformatf("tx_hold%0d", i), dout, 72'(TX_FRAME[71-i]));
      end
    end
    chk("tx_done_early", tx_done, 72'h0);
    @(negedge clk);
    chk("tx_done_pulse", tx_done, 72'h1);
    chk("tx_dout_clr", dout, 72'h0);
    chk("tx_busy_end", tx_busy, 72'h0);
    @(negedge clk);
    chk("tx_done_once", tx_done, 72'h0);
    chk("tx_done_count", 72'(n_tx_done - d0), 72'h1);
    pulse_sh(2);
    chk("idle_strobe_dout", dout, 72'h0);
    chk("idle_strobe_busy", tx_busy, 72'h0);

    // Abort a transmission with RX after 30 strobes
    tx_data = P_TX; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    d0 = n_tx_done;
    for (int i = 0; i < 30; i++) pulse_sh(2);
    RX = 1'b1;
    @(negedge clk);
    chk("abort_busy", tx_busy, 72'h0);
    chk("abort_dout", dout, 72'h0);
    chk("abort_rdy", tx_rdy, 72'h0);
    chk("abort_done", tx_done, 72'h0);
    repeat (3) @(negedge clk);
    chk("abort_done_count", 72'(n_tx_done - d0), 72'h0);
    RX = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
